// File: rtl/fetch_issue_queue.sv
// fetch_issue_queue
// -----------------------------------------------------------------------------
// Fetch-side issue buffer feeding decode stage 1. Instruction words arriving
// from the I-cache fill path (with address, PID and TID) are buffered in a
// small FIFO and handed to the format decoder one per cycle through an
// enable/stall handshake. Every issued instruction gets a unique, monotonically
// increasing major ID. The ID counter survives flushes and wraps silently.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN
//   defined   : a word arriving while the FIFO is empty and decode is not
//               stalled goes straight into the output register (1-edge latency)
//   undefined : every word passes through the FIFO (2-edge latency)
//
// Ports
//   clock_i              rising-edge clock
//   reset_i              synchronous, active-low reset
//   flush_i              drop everything buffered and presented
//   fillValid_i          fill word valid
//   fillInstruction_i    instruction word (bit 0 = MSB)
//   fillAddress_i        instruction address
//   fillPid_i            process ID
//   fillTid_i            thread ID
//   fillReady_o          queue can accept a word this cycle
//   stall_i              decode stall, presented instruction is held
//   outputEnable_o       instruction presented to decode
//   instruction_o        presented word
//   instructionAddress_o presented address
//   instructionPid_o     presented PID
//   instructionTid_o     presented TID
//   instructionMajId_o   major ID of the presented instruction
// -----------------------------------------------------------------------------
module fetch_issue_queue #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int queueDepth              = 4
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic                               fillValid_i,
  input  logic [0:instructionWidth-1]        fillInstruction_i,
  input  logic [addressWidth-1:0]            fillAddress_i,
  input  logic [PidSize-1:0]                 fillPid_i,
  input  logic [TidSize-1:0]                 fillTid_i,
  output logic                               fillReady_o,
  input  logic                               stall_i,
  output logic                               outputEnable_o,
  output logic [0:instructionWidth-1]        instruction_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic [PidSize-1:0]                 instructionPid_o,
  output logic [TidSize-1:0]                 instructionTid_o,
  output logic [instructionCounterWidth-1:0] instructionMajId_o
);

  localparam int ptrWidth   = (queueDepth > 1) ? $clog2(queueDepth) : 1;
  localparam int cntWidth   = ptrWidth + 1;
  localparam int entryWidth = instructionWidth + addressWidth + PidSize + TidSize;

  localparam logic [ptrWidth-1:0]                PtrOne    = ptrWidth'(1'b1);
  localparam logic [cntWidth-1:0]                CntOne    = cntWidth'(1'b1);
  localparam logic [cntWidth-1:0]                CountFull = cntWidth'(queueDepth);
  localparam logic [instructionCounterWidth-1:0] MajOne    = instructionCounterWidth'(1'b1);

  // Storage and output register state
  logic [entryWidth-1:0]              entry_mem_q [queueDepth];
  logic [entryWidth-1:0]              entry_mem_d [queueDepth];
  logic [ptrWidth-1:0]                head_q, head_d;
  logic [ptrWidth-1:0]                tail_q, tail_d;
  logic [cntWidth-1:0]                count_q, count_d;
  logic [instructionCounterWidth-1:0] maj_q, maj_d;
  logic                               out_en_q, out_en_d;
  logic [entryWidth-1:0]              out_entry_q, out_entry_d;
  logic [instructionCounterWidth-1:0] out_id_q, out_id_d;

  // Handshake decode
  logic [entryWidth-1:0] fill_entry_s;
  logic                  fill_ready_s;
  logic                  fifo_empty_s;
  logic                  push_s;
  logic                  bypass_s;
  logic                  store_s;
  logic                  pop_s;

  assign fill_entry_s = {fillInstruction_i, fillAddress_i, fillPid_i, fillTid_i};
  assign fill_ready_s = reset_i && (count_q != CountFull);
  assign fifo_empty_s = (count_q == '0);
  assign push_s       = fillValid_i && fill_ready_s && !flush_i;
`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty FIFO and a free output slot: skip storage entirely.
  assign bypass_s     = push_s && fifo_empty_s && !stall_i;
`else
  assign bypass_s     = 1'b0;
`endif
  assign store_s      = push_s && !bypass_s;
  assign pop_s        = !flush_i && !stall_i && !fifo_empty_s;

  // Next-state: FIFO write/pop, output register load, ID counter, occupancy
  always_comb begin
    entry_mem_d = entry_mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    maj_d       = maj_q;
    out_en_d    = out_en_q;
    out_entry_d = out_entry_q;
    out_id_d    = out_id_q;

    if (flush_i) begin
      // Flush beats stall: the presented slot is invalidated even when held.
      // The ID counter is kept so IDs stay unique across flushes.
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      out_en_d = 1'b0;
    end else begin
      if (store_s) begin
        entry_mem_d[tail_q] = fill_entry_s;
        tail_d              = tail_q + PtrOne;
      end else begin
        tail_d = tail_q;
      end

      if (!stall_i) begin
        if (!fifo_empty_s) begin
          out_entry_d = entry_mem_q[head_q];
          head_d      = head_q + PtrOne;
          out_en_d    = 1'b1;
          out_id_d    = maj_q;
          maj_d       = maj_q + MajOne;
        end else if (bypass_s) begin
          out_entry_d = fill_entry_s;
          out_en_d    = 1'b1;
          out_id_d    = maj_q;
          maj_d       = maj_q + MajOne;
        end else begin
          // Data fields keep their stale contents; only the enable drops.
          out_en_d = 1'b0;
        end
      end else begin
        out_en_d = out_en_q;
      end

      case ({store_s, pop_s})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      for (int i = 0; i < queueDepth; i++) begin
        entry_mem_q[i] <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      maj_q       <= '0;
      out_en_q    <= 1'b0;
      out_entry_q <= '0;
      out_id_q    <= '0;
    end else begin
      entry_mem_q <= entry_mem_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      maj_q       <= maj_d;
      out_en_q    <= out_en_d;
      out_entry_q <= out_entry_d;
      out_id_q    <= out_id_d;
    end
  end

  assign fillReady_o          = fill_ready_s;
  assign outputEnable_o       = out_en_q;
  assign instruction_o        = out_entry_q[entryWidth-1 -: instructionWidth];
  assign instructionAddress_o = out_entry_q[addressWidth+PidSize+TidSize-1 -: addressWidth];
  assign instructionPid_o     = out_entry_q[PidSize+TidSize-1 -: PidSize];
  assign instructionTid_o     = out_entry_q[TidSize-1:0];
  assign instructionMajId_o   = out_id_q;

endmodule

// File: doc/fetch_issue_queue.md
# fetch_issue_queue

Fetch-side issue buffer and the producer for decode stage 1. Accepts 32-bit instruction words with address, PID and TID from the instruction-cache fill path and buffers them in a small FIFO. Presents them one per cycle to the format decoder's `enable_i`/`stall_i` interface, stamping each issued instruction with a unique, monotonically increasing major ID.

## Interface
- `addressWidth`, 64, instruction address width
- `instructionWidth`, 32, instruction word width
- `PidSize`, 20, process ID width
- `TidSize`, 16, thread ID width
- `instructionCounterWidth`, 64, major ID width
- `queueDepth`, 4, FIFO entries (power of two, ≥2)
- `clock_i`  in  1  single clock, all state updates on rising edge
- `reset_i`  in  1  synchronous, active-low reset
- `flush_i`  in  1  discard all buffered and presented instructions
- `fillValid_i`  in  1  fill word valid
- `fillInstruction_i`  in  `instructionWidth`  instruction word, bit 0 = MSB
- `fillAddress_i`  in  `addressWidth`  instruction address
- `fillPid_i`  in  `PidSize`  process ID
- `fillTid_i`  in  `TidSize`  thread ID
- `fillReady_o`  out  1  queue can accept a word this cycle
- `stall_i`  in  1  decode stall; presented instruction is held
- `outputEnable_o`  out  1  instruction presented to decode
- `instruction_o`  out  `instructionWidth`  presented word
- `instructionAddress_o`  out  `addressWidth`  presented address
- `instructionPid_o`  out  `PidSize`  presented PID
- `instructionTid_o`  out  `TidSize`  presented TID
- `instructionMajId_o`  out  `instructionCounterWidth`  major ID of presented instruction

## Operation
- Push: on an edge with `fillValid_i && fillReady_o && !flush_i`, the word, address, PID and TID are written at the tail.
- `fillReady_o = reset_i && (count != queueDepth)`. Combinational from registered count.
- Output register update on every edge with `!stall_i`:
  - If the FIFO is non-empty: load the head into the output register and pop. Set `outputEnable_o=1`, `instructionMajId_o=majCounter`, and `majCounter += 1`.
  - Else: `outputEnable_o=0`. Data outputs hold their old values; they are don't-care.
- With `stall_i=1`: the output register, `outputEnable_o` and the FIFO head all hold. A push may still occur.
- Push and pop on the same edge: count is unchanged. Push at full cannot occur because `fillReady_o=0`.
- `majCounter` wraps from 2^`instructionCounterWidth`−1 to 0 with no flag.
- Flush has priority over push, pop and stall:
  - Count becomes 0 and `outputEnable_o` becomes 0 on the next edge.
  - A simultaneous fill word is dropped.
  - `majCounter` is NOT reset, so IDs stay unique across flushes.
- Reset (`reset_i=0` at an edge):
  - Count, pointers, `majCounter` and all outputs go to 0.
  - `fillReady_o` is 0 while `reset_i=0`.
  - Reset mid-stream discards everything.

## Timing
- Latency, fill to decode (bypass off): a word pushed at edge N is presented after edge N+1 if the FIFO was empty and `stall_i=0` at N+1.
- Throughput: one instruction per cycle sustained while `stall_i=0` and fill is continuous.
- Decode consumes the presented instruction on each edge where `outputEnable_o && !stall_i`.
- `fillReady_o` deasserts in the same cycle the count reaches `queueDepth`. It reasserts in the cycle after a pop from full.
- Registered outputs only; no combinational path from `stall_i` to any output.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - On an edge with FIFO empty, `!stall_i`, `!flush_i` and a valid push, the fill word loads the output register directly.
  - This gives latency 1 edge; the FIFO is not written and `majCounter` increments.
- `FETCH_QUEUE_BYPASS_EN` undefined: every word passes through the FIFO (latency 2 edges).
- All other behaviour is identical in both builds.

## Test plan
- Reset with `reset_i=0` for 2 cycles, then release -> all outputs 0 during reset. After release `fillReady_o=1`, `outputEnable_o=0`.
- Push 3 words (addresses 0x0, 0x4, 0x8; opcode 18 in bits 0:5) with `stall_i=0` -> presented on consecutive cycles with MajId 0, 1, 2. First word appears 2 edges after its push (1 edge with `FETCH_QUEUE_BYPASS_EN`).
- Hold `stall_i=1` and push 5 words with `queueDepth=4` -> `outputEnable_o` and presented word held. `fillReady_o=0` after the FIFO reaches 4 entries, and the extra word is not accepted. Releasing stall drains all entries in order with consecutive MajIds.
- Fill the FIFO, assert `flush_i` together with `fillValid_i` for 1 cycle -> next cycle `outputEnable_o=0`, count 0, fill word dropped. The next issued instruction carries MajId = last ID + 1.
- Force `majCounter` to 2^64−1 and issue 2 instructions -> MajIds 0xFFFF_FFFF_FFFF_FFFF, then 0.
- Assert reset mid-stream with 2 entries buffered and stall active -> next cycle all outputs 0 and the FIFO empty. Nothing is presented after release until a new push.
